// File: rtl/barrel_spawn_pool.sv
// Shared pool of horizontal/vertical barrel slots. Player-2 spawn keys are queued
// and granted to the lowest free slot of the matching type, paced by a cooldown.
module barrel_spawn_pool #(
    parameter int                 BARRELS    = 10,
    parameter logic [BARRELS-1:0] VER_MASK   = 10'b1111100000,
    parameter int                 DELAY_TIME = 20_500_000,
    parameter int                 QDEPTH     = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start_game,
    input  logic                       animation,
    input  logic                       key_hor,
    input  logic                       key_ver,
    input  logic [BARRELS-1:0]         done,
    input  logic [BARRELS-1:0]         hit,
    output logic [BARRELS-1:0]         barrel,
    output logic                       game_over,
    output logic                       drop,
    output logic [7:0]                 spawn_count,
    output logic [$clog2(QDEPTH):0]    queue_level
);

    localparam int AW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
    localparam int LW = $clog2(QDEPTH) + 1;
    localparam int CW = (DELAY_TIME > 1) ? $clog2(DELAY_TIME) : 1;

    typedef enum logic [1:0] {IDLE, READY, COOL, HALT} state_t;

    state_t            state;
    logic [CW-1:0]     cool_cnt;
    logic              key_hor_q;
    logic              key_ver_q;
    logic              fifo_mem [QDEPTH];
    logic [AW-1:0]     rd_ptr;
    logic [AW-1:0]     wr_ptr;

    logic               en;
    logic               req_hor;
    logic               req_ver;
    logic               push_en;
    logic               push;
    logic               push_ver;
    logic               fifo_empty;
    logic               fifo_full;
    logic               head_ver;
    logic [BARRELS-1:0] free_match;
    logic [BARRELS-1:0] alloc;
    logic               pop;
    logic               accept;
    logic               drop_next;
    logic [BARRELS-1:0] grant;

    assign en       = start_game & ~animation;
    assign req_hor  = key_hor & ~key_hor_q;
    assign req_ver  = key_ver & ~key_ver_q;
    assign push_en  = en & ~game_over & ((state == READY) || (state == COOL));
    assign push     = push_en & (req_hor | req_ver);
    // A simultaneous hor+ver rise keeps only the horizontal request.
    assign push_ver = req_ver & ~req_hor;

    assign fifo_empty = (queue_level == '0);
    assign fifo_full  = (queue_level == LW'(QDEPTH));
    assign head_ver   = fifo_mem[rd_ptr];

    assign free_match = ~barrel & (head_ver ? VER_MASK : ~VER_MASK);
    // Isolate the lowest set bit: the lowest-index free slot of the head's type.
    assign alloc      = free_match & (~free_match + BARRELS'(1));

    assign pop       = (state == READY) & en & ~game_over & ~fifo_empty & (|free_match);
    assign accept    = push & (~fifo_full | pop);
    assign drop_next = push & ((req_hor & req_ver) | (fifo_full & ~pop));
    assign grant     = pop ? alloc : '0;

    // NOTE: the FIFO storage carries no reset; pointers and level alone define validity,
    // so the array maps onto plain registers/RAM without a reset net.
    always_ff @(posedge clk) begin
        if (accept) begin
            fifo_mem[wr_ptr] <= push_ver;
        end
    end

    // NOTE: all state below uses non-blocking assignments so every register samples
    // the pre-edge values of its neighbours, independent of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            cool_cnt    <= '0;
            key_hor_q   <= 1'b0;
            key_ver_q   <= 1'b0;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            queue_level <= '0;
            barrel      <= '0;
            game_over   <= 1'b0;
            drop        <= 1'b0;
            spawn_count <= '0;
        end else begin
            key_hor_q <= key_hor;
            key_ver_q <= key_ver;
            game_over <= game_over | (|(hit & barrel));
            drop      <= drop_next;

            if (!en || (state == IDLE)) begin
                state       <= en ? READY : IDLE;
                cool_cnt    <= '0;
                rd_ptr      <= '0;
                wr_ptr      <= '0;
                queue_level <= '0;
                barrel      <= '0;
            end else begin
                barrel <= (barrel | grant) & ~done;

                if (accept) begin
                    wr_ptr <= wr_ptr + AW'(1);
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + AW'(1);
                end
                if (accept && !pop) begin
                    queue_level <= queue_level + LW'(1);
                end else if (!accept && pop) begin
                    queue_level <= queue_level - LW'(1);
                end

                case (state)
                    READY: begin
                        if (game_over) begin
                            state <= HALT;
                        end else if (pop) begin
                            spawn_count <= spawn_count + 8'd1;
                            cool_cnt    <= CW'(DELAY_TIME - 1);
                            state       <= COOL;
                        end
                    end
                    COOL: begin
                        if (game_over) begin
                            state <= HALT;
                        end else if (cool_cnt == '0) begin
                            state <= READY;
                        end else begin
                            cool_cnt <= cool_cnt - CW'(1);
                        end
                    end
                    default: state <= HALT;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_barrel_spawn_pool.sv
// Self-checking bench for barrel_spawn_pool: directed scenarios then random traffic,
// every cycle compared against a queue-based reference model.
module tb_barrel_spawn_pool;

    localparam int         BARRELS    = 4;
    localparam logic [3:0] VER_MASK   = 4'b1100;
    localparam int         DELAY_TIME = 4;
    localparam int         QDEPTH     = 2;

    logic       clk = 1'b0;
    logic       rst;
    logic       start_game;
    logic       animation;
    logic       key_hor;
    logic       key_ver;
    logic [3:0] done;
    logic [3:0] hit;
    logic [3:0] barrel;
    logic       game_over;
    logic       drop;
    logic [7:0] spawn_count;
    logic [1:0] queue_level;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    barrel_spawn_pool #(
        .BARRELS(BARRELS), .VER_MASK(VER_MASK),
        .DELAY_TIME(DELAY_TIME), .QDEPTH(QDEPTH)
    ) dut (
        .clk(clk), .rst(rst), .start_game(start_game), .animation(animation),
        .key_hor(key_hor), .key_ver(key_ver), .done(done), .hit(hit),
        .barrel(barrel), .game_over(game_over), .drop(drop),
        .spawn_count(spawn_count), .queue_level(queue_level)
    );

    always #5 clk = ~clk;

    // Reference model: game phase flags, earliest spawn cycle, and a queue of request types.
    bit         m_idle;
    bit         m_halt;
    bit         m_go;
    bit         m_drop;
    int         m_ready_at;
    bit         m_q[$];
    logic [3:0] m_barrel;
    logic [7:0] m_cnt;
    bit         m_kh;
    bit         m_kv;

    task automatic model_reset();
        m_idle = 1; m_halt = 0; m_go = 0; m_drop = 0; m_ready_at = 0;
        m_q.delete(); m_barrel = '0; m_cnt = '0; m_kh = 0; m_kv = 0;
    endtask

    task automatic model_step();
        bit         en;
        bit         rh;
        bit         rv;
        logic [3:0] bold;
        logic [3:0] grant;
        en    = start_game & ~animation;
        rh    = key_hor & ~m_kh;
        rv    = key_ver & ~m_kv;
        bold  = m_barrel;
        grant = '0;
        m_drop = 0;
        if (!en) begin
            m_idle = 1; m_halt = 0; m_barrel = '0; m_q.delete();
        end else if (m_idle) begin
            m_idle = 0; m_ready_at = cyc + 1;
        end else if (m_halt || m_go) begin
            m_halt = 1; m_barrel = bold & ~done;
        end else begin
            if (cyc >= m_ready_at && m_q.size() > 0) begin
                for (int i = 0; i < BARRELS; i++)
                    if (grant == '0 && !bold[i] && VER_MASK[i] == m_q[0]) grant[i] = 1'b1;
                if (grant != '0) begin
                    void'(m_q.pop_front());
                    m_cnt = m_cnt + 8'd1;
                    m_ready_at = cyc + DELAY_TIME + 1;
                end
            end
            if (rh || rv) begin
                if (rh && rv) m_drop = 1;
                if (m_q.size() >= QDEPTH) m_drop = 1;
                else m_q.push_back(rh ? 1'b0 : 1'b1);
            end
            m_barrel = (bold | grant) & ~done;
        end
        m_go = m_go | (|(hit & bold));
        m_kh = key_hor;
        m_kv = key_ver;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic compare_all();
        check("barrel", 32'(barrel), 32'(m_barrel));
        check("game_over", 32'(game_over), 32'(m_go));
        check("drop", 32'(drop), 32'(m_drop));
        check("spawn_count", 32'(spawn_count), 32'(m_cnt));
        check("queue_level", 32'(queue_level), 32'(m_q.size()));
    endtask

    task automatic tick();
        @(posedge clk);
        cyc++;
        model_step();
        #1;
        compare_all();
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic press(input bit h, input bit v);
        key_hor = h; key_ver = v;
        tick();
        key_hor = 0; key_ver = 0;
        tick();
    endtask

    task automatic async_reset();
        @(posedge clk);
        cyc++;
        model_step();
        #3;
        rst = 1'b1;
        #1;
        model_reset();
        compare_all();
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; start_game = 0; animation = 0;
        key_hor = 0; key_ver = 0; done = '0; hit = '0;
        model_reset();
        #3;
        compare_all();
        @(negedge clk);
        rst = 1'b0;

        // 1: single horizontal spawn, two clocks after the key rises
        start_game = 1;
        ticks(3);
        key_hor = 1;
        tick();
        key_hor = 0;
        tick();
        check("t1_barrel_const", 32'(barrel), 32'h1);
        check("t1_count_const", 32'(spawn_count), 32'd1);
        ticks(2);

        // 2: three vertical presses during cooldown, then free slot 2 again
        press(0, 1); press(0, 1); press(0, 1);
        ticks(8);
        done = 4'b0100;
        tick();
        done = '0;
        ticks(8);

        // 3: occupy both hor slots, fill FIFO with hor requests, overflow press
        done = 4'b1100;
        tick();
        done = '0;
        press(1, 0);
        ticks(6);
        press(1, 0); press(1, 0); press(1, 0);
        ticks(3);

        // 4: simultaneous rise of both keys
        done = 4'b0011;
        tick();
        done = '0;
        ticks(6);
        press(1, 1);
        ticks(8);

        // 5: hit on an inactive slot, then on an active one; presses afterwards ignored
        done = 4'b1000;
        tick();
        done = '0;
        hit = 4'b1000;
        tick();
        hit = '0;
        ticks(2);
        press(1, 0);
        ticks(6);
        hit = 4'b0001;
        tick();
        hit = '0;
        ticks(2);
        press(1, 0); press(0, 1);
        ticks(3);

        // 6a: animation clears slots and FIFO but game_over stays
        animation = 1;
        ticks(3);
        animation = 0;
        ticks(2);

        // 6b: async reset during cooldown with two slots active
        async_reset();
        ticks(2);
        press(1, 0);
        ticks(6);
        press(0, 1);
        ticks(2);
        async_reset();
        ticks(2);

        // random traffic in several reset-separated segments
        for (int seg = 0; seg < 6; seg++) begin
            for (int c = 0; c < 400; c++) begin
                key_hor    = ($urandom_range(0, 3) == 0) ? ~key_hor : key_hor;
                key_ver    = ($urandom_range(0, 3) == 0) ? ~key_ver : key_ver;
                done       = ($urandom_range(0, 5) == 0) ? 4'($urandom) : 4'b0;
                hit        = ($urandom_range(0, 250) == 0) ? 4'($urandom) : 4'b0;
                animation  = ($urandom_range(0, 120) == 0);
                start_game = ($urandom_range(0, 150) != 0);
                tick();
            end
            key_hor = 0; key_ver = 0; done = '0; hit = '0;
            animation = 0; start_game = 1;
            async_reset();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
